// File: rtl/id_stage_if.sv
// Handshake bundles on either side of the decode stage:
// the fetched-instruction channel and the decoded ID/EX channel.
interface id_in_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;

  modport master (output valid, inst, pc, input ready);
  modport slave  (input valid, inst, pc, output ready);
endinterface

interface id_out_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               valid;
  logic               ready;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    imm;
  logic [RADDR_W-1:0] rd;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               is_load;
  logic               illegal;

  modport master (output valid, pc, rs1_val, rs2_val, imm, rd, opcode, funct3,
                  funct7b5, is_load, illegal, input ready);
  modport slave  (input valid, pc, rs1_val, rs2_val, imm, rd, opcode, funct3,
                  funct7b5, is_load, illegal, output ready);
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: field split, register-file operand fetch with writeback
// bypass, immediate generation, load-use stall and the ID/EX output register.
module id_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  id_in_if.slave             in_if,
  input  logic               flush,
  output logic [RADDR_W-1:0] r_addr_a,
  input  logic [XLEN-1:0]    r_data_a,
  output logic [RADDR_W-1:0] r_addr_b,
  input  logic [XLEN-1:0]    r_data_b,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  id_out_if.master           out_if
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0]        inst;
  logic [6:0]         opcode;
  logic [RADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]    rs1_val, rs2_val, imm;
  logic               illegal, uses_rs2, stall, in_ready, accept;

  logic               valid_q, is_load_q, funct7b5_q, illegal_q;
  logic [XLEN-1:0]    pc_q, rs1_q, rs2_q, imm_q;
  logic [RADDR_W-1:0] rd_q;
  logic [6:0]         opcode_q;
  logic [2:0]         funct3_q;

  assign inst     = in_if.inst;
  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign r_addr_a = rs1;
  assign r_addr_b = rs2;

  // The register file write only lands at the edge, so same-cycle writeback wins over its read data.
  assign rs1_val = (rs1 == '0) ? '0 : (wb_en && wb_addr == rs1) ? wb_data : r_data_a;
  assign rs2_val = (rs2 == '0) ? '0 : (wb_en && wb_addr == rs2) ? wb_data : r_data_b;

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_REG:
        imm = '0;
      default:
        illegal = 1'b1;
    endcase
  end

  // Only R, S and B formats actually read rs2; other formats reuse those bits as immediate.
  assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign stall    = valid_q && is_load_q && (rd_q != '0) &&
                    ((rd_q == rs1) || (uses_rs2 && (rd_q == rs2)));
  assign in_ready = flush || ((!valid_q || out_if.ready) && !stall);
  assign accept   = in_if.valid && in_ready;

  assign in_if.ready = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      is_load_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      pc_q       <= in_if.pc;
      rs1_q      <= rs1_val;
      rs2_q      <= rs2_val;
      imm_q      <= imm;
      rd_q       <= rd;
      opcode_q   <= opcode;
      funct3_q   <= inst[14:12];
      funct7b5_q <= inst[30];
      is_load_q  <= (opcode == OP_LOAD);
      illegal_q  <= illegal;
    end else if (out_if.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_if.valid    = valid_q;
  assign out_if.pc       = pc_q;
  assign out_if.rs1_val  = rs1_q;
  assign out_if.rs2_val  = rs2_q;
  assign out_if.imm      = imm_q;
  assign out_if.rd       = rd_q;
  assign out_if.opcode   = opcode_q;
  assign out_if.funct3   = funct3_q;
  assign out_if.funct7b5 = funct7b5_q;
  assign out_if.is_load  = is_load_q;
  assign out_if.illegal  = illegal_q;

endmodule
